hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hilo_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO controller: sequences an external divider/multiplier, applies sign fix-up and owns HI/LO.
// Define HILO_SIGNED_EN for signed arithmetic; undefined gives plain unsigned pass-through.
module hilo_ctrl #(
  parameter int DIV_LAT  = 35,
  parameter int MULT_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_div,
  input  logic        start_mult,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        abort,
  output logic [31:0] div_n,
  output logic [31:0] div_d,
  output logic        div_init,
  output logic        div_stop,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_zero,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mult_init,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic [2:0]  dbg_state
);
  localparam int MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [2:0] {IDLE, DIV_WAIT, MULT_WAIT, FIX, DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_is_div, r_div_init, r_mult_init, r_div_stop, r_div0_exc;
  logic [31:0]   r_div_n, r_div_d, r_mul_a, r_mul_b, r_hi, r_lo, r_t_hi, r_t_lo;
  logic          w_idle, w_wait, w_start_div, w_start_mult, w_abort, w_div0, w_cnt_zero;
  logic [31:0]   w_mag_a, w_mag_b, w_quo, w_rem;
  logic [63:0]   w_prod;

  assign w_idle       = (r_state == IDLE);
  assign w_wait       = (r_state == DIV_WAIT) || (r_state == MULT_WAIT);
  assign w_start_div  = w_idle && start_div;
  assign w_start_mult = w_idle && start_mult && !start_div;
  assign w_abort      = !w_idle && abort;
  assign w_div0       = (r_state == DIV_WAIT) && div_zero && !abort;
  assign w_cnt_zero   = (r_cnt == '0);

`ifdef HILO_SIGNED_EN
  logic r_sign_a, r_sign_b;

  assign w_mag_a = rs[31] ? -rs : rs;
  assign w_mag_b = rt[31] ? -rt : rt;
  // Quotient/product negate when signs differ; remainder follows the dividend.
  assign w_quo   = (r_sign_a ^ r_sign_b) ? -r_t_lo : r_t_lo;
  assign w_rem   = r_sign_a ? -r_t_hi : r_t_hi;
  assign w_prod  = (r_sign_a ^ r_sign_b) ? -{r_t_hi, r_t_lo} : {r_t_hi, r_t_lo};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else if (w_start_div || w_start_mult) begin
      r_sign_a <= rs[31];
      r_sign_b <= rt[31];
    end
  end
`else
  assign w_mag_a = rs;
  assign w_mag_b = rt;
  assign w_quo   = r_t_lo;
  assign w_rem   = r_t_hi;
  assign w_prod  = {r_t_hi, r_t_lo};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start_div) w_next = DIV_WAIT;
                 else if (start_mult) w_next = MULT_WAIT;
      DIV_WAIT:  if (abort || div_zero) w_next = IDLE;
                 else if (w_cnt_zero) w_next = FIX;
      MULT_WAIT: if (abort) w_next = IDLE;
                 else if (w_cnt_zero) w_next = FIX;
      FIX:       w_next = abort ? IDLE : DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_div_init  <= 1'b0;
      r_mult_init <= 1'b0;
      r_div_stop  <= 1'b1;
      r_div0_exc  <= 1'b0;
      r_div_n     <= '0;
      r_div_d     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_t_hi      <= '0;
      r_t_lo      <= '0;
    end else begin
      r_state     <= w_next;
      r_div_init  <= w_start_div;
      r_mult_init <= w_start_mult;
      r_div_stop  <= w_abort || w_div0;
      r_div0_exc  <= w_div0;
      if (w_start_div) begin
        r_div_n  <= w_mag_a;
        r_div_d  <= w_mag_b;
        r_cnt    <= CW'(DIV_LAT);
        r_is_div <= 1'b1;
      end else if (w_start_mult) begin
        r_mul_a  <= w_mag_a;
        r_mul_b  <= w_mag_b;
        r_cnt    <= CW'(MULT_LAT);
        r_is_div <= 1'b0;
      end else if (w_wait) begin
        if (!w_cnt_zero) begin
          r_cnt <= r_cnt - CW'(1);
        end else begin
          r_t_hi <= r_is_div ? div_hi : mult_hi;
          r_t_lo <= r_is_div ? div_lo : mult_lo;
        end
      end
      if (w_idle && mthi) r_hi <= wdata;
      if (w_idle && mtlo) r_lo <= wdata;
      if (r_state == FIX && !abort) begin
        r_hi <= r_is_div ? w_rem : w_prod[63:32];
        r_lo <= r_is_div ? w_quo : w_prod[31:0];
      end
    end
  end

  assign div_n     = r_div_n;
  assign div_d     = r_div_d;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign div_init  = r_div_init;
  assign mult_init = r_mult_init;
  assign div_stop  = r_div_stop;
  assign div0_exc  = r_div0_exc;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = !w_idle;
  assign done      = (r_state == DONE) && !abort;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: latency-accurate divider/multiplier models, event scoreboard, directed vectors.
module tb_hilo_ctrl;
  localparam int DIV_LAT  = 35;
  localparam int MULT_LAT = 33;
  localparam int W = 66;
  localparam logic [1:0] K_DINIT = 2'd0, K_MINIT = 2'd1, K_DONE = 2'd2, K_DIV0 = 2'd3;

  logic        clk = 1'b0;
  logic        rst, start_div, start_mult, mthi, mtlo, abort;
  logic [31:0] wdata, rs, rt;
  logic [31:0] div_n, div_d, div_hi, div_lo, mul_a, mul_b, mult_hi, mult_lo, hi, lo;
  logic        div_init, div_stop, div_zero, mult_init, busy, done, div0_exc;
  logic [2:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  hilo_ctrl #(.DIV_LAT(DIV_LAT), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst(rst), .start_div(start_div), .start_mult(start_mult),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rs(rs), .rt(rt), .abort(abort),
    .div_n(div_n), .div_d(div_d), .div_init(div_init), .div_stop(div_stop),
    .div_hi(div_hi), .div_lo(div_lo), .div_zero(div_zero),
    .mul_a(mul_a), .mul_b(mul_b), .mult_init(mult_init),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0_exc(div0_exc),
    .dbg_state(dbg_state)
  );

  // Divider model: result valid DIV_LAT cycles after div_init, garbage before.
  logic        dv_act, mm_act;
  int          dv_cnt, mm_cnt;
  logic [31:0] dv_n, dv_d, mm_a, mm_b;
  logic [63:0] mm_p;

  always @(posedge clk) begin
    if (!rst) dv_act <= 1'b0;
    else if (div_init) begin
      dv_act <= 1'b1; dv_cnt <= DIV_LAT - 1; dv_n <= div_n; dv_d <= div_d;
    end else if (div_stop) dv_act <= 1'b0;
    else if (dv_act && dv_cnt != 0) dv_cnt <= dv_cnt - 1;
  end

  always @(posedge clk) begin
    if (!rst) mm_act <= 1'b0;
    else if (mult_init) begin
      mm_act <= 1'b1; mm_cnt <= MULT_LAT - 1; mm_a <= mul_a; mm_b <= mul_b;
    end else if (mm_act && mm_cnt != 0) mm_cnt <= mm_cnt - 1;
  end

  assign mm_p     = {32'd0, mm_a} * {32'd0, mm_b};
  assign div_zero = dv_act && (dv_d == 32'd0);
  assign div_hi   = (dv_act && dv_cnt == 0 && dv_d != 0) ? dv_n % dv_d : 32'hDEADBEEF;
  assign div_lo   = (dv_act && dv_cnt == 0 && dv_d != 0) ? dv_n / dv_d : 32'hDEADBEEF;
  assign mult_hi  = (mm_act && mm_cnt == 0) ? mm_p[63:32] : 32'hDEADBEEF;
  assign mult_lo  = (mm_act && mm_cnt == 0) ? mm_p[31:0]  : 32'hDEADBEEF;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({k, a, b});
  endtask

  task automatic mon_event(input logic [1:0] k, input string nm, input logic [31:0] a,
                           input logic [31:0] b);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected_event actual_a=%0h actual_b=%0h expected=none", nm, a, b);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, 64'(k), 64'(e[65:64]));
      check({nm, "_a"}, 64'(a), 64'(e[63:32]));
      check({nm, "_b"}, 64'(b), 64'(e[31:0]));
    end
  endtask

  // Monitor: every DUT output event pops one expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (div_init)  mon_event(K_DINIT, "div_init", div_n, div_d);
      if (mult_init) mon_event(K_MINIT, "mult_init", mul_a, mul_b);
      if (done)      mon_event(K_DONE, "done", hi, lo);
      if (div0_exc) begin
        mon_event(K_DIV0, "div0", hi, lo);
        check("div0_div_stop", 64'(div_stop), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout actual=busy expected=idle_within_%0d", bound);
    end
  endtask

  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ma, input logic [31:0] mb,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    push(is_div ? K_DINIT : K_MINIT, ma, mb);
    push(K_DONE, ehi, elo);
    rs = a; rt = b;
    if (is_div) start_div = 1'b1; else start_mult = 1'b1;
    tick();
    start_div = 1'b0; start_mult = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    wait_idle(200, n);
    check("op_cycles", 64'(n), is_div ? 64'(DIV_LAT + 3) : 64'(MULT_LAT + 3));
    check("op_hi", 64'(hi), 64'(ehi));
    check("op_lo", 64'(lo), 64'(elo));
    exp_hi = ehi; exp_lo = elo;
  endtask

  initial begin
    int n;
    rst = 1'b0; start_div = 1'b0; start_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    abort = 1'b0; wdata = '0; rs = '0; rt = '0;
    tick(); tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_div_stop", 64'(div_stop), 64'd1);
    check("rst_inits", 64'({div_init, mult_init, done, div0_exc}), 64'd0);
    check("rst_operands", 64'(div_n | div_d | mul_a | mul_b), 64'd0);
    rst = 1'b1;
    tick();

    // Simultaneous mthi/mtlo in IDLE
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_hi", 64'(hi), 64'h12345678);
    check("mt_lo", 64'(lo), 64'h12345678);
    check("mt_busy", 64'(busy), 64'd0);

    // Divide by zero keeps prior HI/LO
    mthi = 1'b1; wdata = 32'h11111111; tick(); mthi = 1'b0;
    mtlo = 1'b1; wdata = 32'h22222222; tick(); mtlo = 1'b0;
    push(K_DINIT, 32'd100, 32'd0);
    push(K_DIV0, 32'h11111111, 32'h22222222);
    rs = 32'd100; rt = 32'd0; start_div = 1'b1;
    tick();
    start_div = 1'b0;
    wait_idle(50, n);
    check("div0_hi", 64'(hi), 64'h11111111);
    check("div0_lo", 64'(lo), 64'h22222222);

`ifdef HILO_SIGNED_EN
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, 32'd100, 32'd7, 32'd2, 32'hFFFFFFF2);
    run_op(1'b0, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd3, 32'd5, 32'd0, 32'd15);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd0, 32'h80000000);
`else
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC);
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, 32'd100, 32'hFFFFFFF9, 32'd100, 32'd0);
    run_op(1'b0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
    run_op(1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'hFFFFFFF8, 32'd15);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
`endif

    // Requests while busy are ignored
    push(K_DINIT, 32'd9, 32'd3);
    push(K_DONE, 32'd0, 32'd3);
    rs = 32'd9; rt = 32'd3; start_div = 1'b1;
    tick();
    start_div = 1'b0;
    repeat (3) tick();
    start_mult = 1'b1; mthi = 1'b1; wdata = 32'hFFFF0000;
    tick();
    start_mult = 1'b0; mthi = 1'b0;
    check("busy_mthi_ignored", 64'(hi), 64'(exp_hi));
    wait_idle(200, n);
    check("busy_op_lo", 64'(lo), 64'd3);

    // mtlo and start_mult in the same cycle: both take effect
    push(K_MINIT, 32'd3, 32'd4);
    push(K_DONE, 32'd0, 32'd12);
    rs = 32'd3; rt = 32'd4; start_mult = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A5A5A;
    tick();
    start_mult = 1'b0; mtlo = 1'b0;
    check("mtlo_with_start", 64'(lo), 64'h5A5A5A5A);
    wait_idle(200, n);
    check("mult_3x4_lo", 64'(lo), 64'd12);
    exp_hi = 32'd0; exp_lo = 32'd12;

    // Abort mid-divide, with an ignored mthi just before
    push(K_DINIT, 32'd50, 32'd5);
    rs = 32'd50; rt = 32'd5; start_div = 1'b1;
    tick();
    start_div = 1'b0;
    repeat (9) tick();
    mthi = 1'b1; wdata = 32'hAAAA5555;
    tick();
    mthi = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_div_stop", 64'(div_stop), 64'd1);
    check("abort_hi", 64'(hi), 64'(exp_hi));
    check("abort_lo", 64'(lo), 64'(exp_lo));
    repeat (45) tick();
    check("abort_still_idle", 64'(busy), 64'd0);

    // Simultaneous starts (div wins), then reset mid-operation
    push(K_DINIT, 32'd20, 32'd4);
    rs = 32'd20; rt = 32'd4; start_div = 1'b1; start_mult = 1'b1;
    tick();
    start_div = 1'b0; start_mult = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_div_stop", 64'(div_stop), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();
    check("post_rst_div_stop", 64'(div_stop), 64'd0);
    repeat (40) tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
